l2_bank_mapper_xbar: RTL and testbench

// - Generalised L2 front-end: N mem-protocol ports (req/gnt/rvalid, post axi_to_mem) onto M single-port SRAM banks.
// - Runtime map rules select interleaved or contiguous addressing per window; round-robin arbitration per bank.
// - Fixed-latency, in-order response routing per port; decode misses return an error with no bank access.
// - Sits between per-port AXI-to-mem converters and the L2 bank macros; replaces fixed two-port, two-mode mapping.

---
 rtl/l2_map_pkg.sv | 21 ++
 rtl/l2_bank_rr_arb.sv | 42 ++++
 rtl/l2_bank_mapper_xbar.sv | 173 +++++++++++++++++
 tb/tb_l2_bank_mapper_xbar.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_map_pkg.sv
// Shared types for the L2 bank mapper: address-map rule layout and window modes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package l2_map_pkg;

  // Width of the address fields carried inside a map rule.
  localparam int unsigned MapAddrWidth = 48;

  typedef enum logic {
    INTERLEAVE = 1'b0,
    CONTIGUOUS = 1'b1
  } map_mode_e;

  // A window [start_addr, end_addr) and how words inside it spread over the banks.
  typedef struct packed {
    map_mode_e               mode;
    logic [MapAddrWidth-1:0] start_addr;
    logic [MapAddrWidth-1:0] end_addr;
  } map_rule_t;

endpackage

// File: rtl/l2_bank_rr_arb.sv
// Round-robin arbiter for one SRAM bank: picks one requesting port, onehot grant.
// Latency: grant is combinational; the priority pointer advances on the following edge.
// Backpressure: losers get no grant and are expected to hold their request.
module l2_bank_rr_arb #(
  parameter int unsigned NumPort = 2,
  localparam int unsigned PtrW = (NumPort > 1) ? $clog2(NumPort) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NumPort-1:0] req_i,
  output logic [NumPort-1:0] gnt_o
);

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] winner;
  int              cand;

  // Scan from the far end back towards ptr so the requester closest to ptr is written last and wins.
  always_comb begin
    gnt_o  = '0;
    winner = '0;
    cand   = 0;
    for (int i = NumPort - 1; i >= 0; i--) begin
      cand = (int'(ptr_q) + i) % int'(NumPort);
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        winner      = PtrW'(cand);
      end
    end
  end

  // Move priority to the port after the winner; hold it when nobody asked.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (|req_i) begin
      ptr_q <= (int'(winner) == int'(NumPort) - 1) ? '0 : winner + PtrW'(1);
    end
  end

endmodule

// File: rtl/l2_bank_mapper_xbar.sv
// L2 front-end: decodes port addresses via runtime rules and crossbars them onto single-port banks.
// Latency: grant and bank access in the request cycle; rvalid exactly MemLatency cycles after grant.
// Backpressure: gnt stays low for a port that lost bank arbitration; decode misses are granted at once.
module l2_bank_mapper_xbar
  import l2_map_pkg::*;
#(
  parameter int unsigned NumPort    = 2,
  parameter int unsigned NumBank    = 4,
  parameter int unsigned AddrWidth  = 48,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned L2MemSize  = 32'd1 << 20,
  parameter int unsigned NumRules   = 4,
  parameter int unsigned MemLatency = 1,
  localparam int unsigned ByteW         = DataWidth / 8,
  localparam int unsigned RowsPerBank   = L2MemSize / ByteW / NumBank,
  localparam int unsigned BankAddrWidth = $clog2(RowsPerBank)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  map_rule_t [NumRules-1:0]                map_rules_i,
  input  logic      [NumPort-1:0]                 port_req_i,
  output logic      [NumPort-1:0]                 port_gnt_o,
  input  logic      [NumPort-1:0][AddrWidth-1:0]  port_addr_i,
  input  logic      [NumPort-1:0]                 port_we_i,
  input  logic      [NumPort-1:0][ByteW-1:0]      port_be_i,
  input  logic      [NumPort-1:0][DataWidth-1:0]  port_wdata_i,
  output logic      [NumPort-1:0]                 port_rvalid_o,
  output logic      [NumPort-1:0][DataWidth-1:0]  port_rdata_o,
  output logic      [NumPort-1:0]                 port_err_o,
  output logic      [NumBank-1:0]                 bank_req_o,
  output logic      [NumBank-1:0]                 bank_we_o,
  output logic      [NumBank-1:0][BankAddrWidth-1:0] bank_addr_o,
  output logic      [NumBank-1:0][ByteW-1:0]      bank_be_o,
  output logic      [NumBank-1:0][DataWidth-1:0]  bank_wdata_o,
  input  logic      [NumBank-1:0][DataWidth-1:0]  bank_rdata_i
);

  localparam int unsigned OffW     = $clog2(ByteW);
  localparam int unsigned BankSelW = $clog2(NumBank);
  localparam int unsigned IdxW     = BankSelW + BankAddrWidth;

  logic [NumPort-1:0]                     dec_hit;
  logic [NumPort-1:0][BankSelW-1:0]       dec_bank;
  logic [NumPort-1:0][BankAddrWidth-1:0]  dec_row;
  logic [IdxW-1:0]                        word_idx;
  logic [AddrWidth-1:0]                   rule_start;
  logic [AddrWidth-1:0]                   rule_end;

  logic [NumBank-1:0][NumPort-1:0]        arb_req;
  logic [NumBank-1:0][NumPort-1:0]        bank_gnt;

  // Response pipe, one lane per port: {valid, err, we, bank} shifted MemLatency times.
  logic [NumPort-1:0][MemLatency-1:0]               pipe_vld;
  logic [NumPort-1:0][MemLatency-1:0]               pipe_err;
  logic [NumPort-1:0][MemLatency-1:0]               pipe_we;
  logic [NumPort-1:0][MemLatency-1:0][BankSelW-1:0] pipe_bank;

  // Decode each port; rules are scanned top-down so the lowest-index hit is the one that sticks.
  always_comb begin
    dec_hit    = '0;
    dec_bank   = '0;
    dec_row    = '0;
    word_idx   = '0;
    rule_start = '0;
    rule_end   = '0;
    for (int p = 0; p < NumPort; p++) begin
      for (int r = NumRules - 1; r >= 0; r--) begin
        rule_start = map_rules_i[r].start_addr[AddrWidth-1:0];
        rule_end   = map_rules_i[r].end_addr[AddrWidth-1:0];
        if (port_addr_i[p] >= rule_start && port_addr_i[p] < rule_end) begin
          word_idx   = IdxW'((port_addr_i[p] - rule_start) >> OffW);
          // A window larger than the physical L2 cannot be mapped; treat it as unmapped.
          dec_hit[p] = (rule_end - rule_start) <= AddrWidth'(L2MemSize);
          if (map_rules_i[r].mode == INTERLEAVE) begin
            dec_bank[p] = word_idx[BankSelW-1:0];
            dec_row[p]  = word_idx[BankSelW +: BankAddrWidth];
          end else begin
            dec_row[p]  = word_idx[BankAddrWidth-1:0];
            dec_bank[p] = word_idx[BankAddrWidth +: BankSelW];
          end
        end
      end
    end
  end

  // Steer decoded hits to their bank arbiter; nothing reaches a bank while reset is held.
  always_comb begin
    arb_req = '0;
    for (int b = 0; b < NumBank; b++) begin
      for (int p = 0; p < NumPort; p++) begin
        arb_req[b][p] = port_req_i[p] & dec_hit[p] & ~rst_i &
                        (dec_bank[p] == BankSelW'(b));
      end
    end
  end

  for (genvar b = 0; b < NumBank; b++) begin : g_bank_arb
    l2_bank_rr_arb #(
      .NumPort (NumPort)
    ) u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (arb_req[b]),
      .gnt_o (bank_gnt[b])
    );
  end

  // Misses are granted immediately; hits are granted by whichever bank arbiter picked them.
  always_comb begin
    port_gnt_o = port_req_i & ~dec_hit & {NumPort{~rst_i}};
    for (int b = 0; b < NumBank; b++) begin
      port_gnt_o = port_gnt_o | bank_gnt[b];
    end
  end

  // Bank-side mux: forward the winning port's command to each bank.
  always_comb begin
    bank_req_o   = '0;
    bank_we_o    = '0;
    bank_addr_o  = '0;
    bank_be_o    = '0;
    bank_wdata_o = '0;
    for (int b = 0; b < NumBank; b++) begin
      bank_req_o[b] = |bank_gnt[b];
      for (int p = 0; p < NumPort; p++) begin
        if (bank_gnt[b][p]) begin
          bank_we_o[b]    = port_we_i[p];
          bank_addr_o[b]  = dec_row[p];
          bank_be_o[b]    = port_be_i[p];
          bank_wdata_o[b] = port_wdata_i[p];
        end
      end
    end
  end

  // Track every grant through a fixed-depth pipe matching the bank read latency; reset drops in-flight entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pipe_vld  <= '0;
      pipe_err  <= '0;
      pipe_we   <= '0;
      pipe_bank <= '0;
    end else begin
      for (int p = 0; p < NumPort; p++) begin
        pipe_vld[p][0]  <= port_gnt_o[p];
        pipe_err[p][0]  <= ~dec_hit[p];
        pipe_we[p][0]   <= port_we_i[p];
        pipe_bank[p][0] <= dec_bank[p];
        for (int s = 1; s < MemLatency; s++) begin
          pipe_vld[p][s]  <= pipe_vld[p][s-1];
          pipe_err[p][s]  <= pipe_err[p][s-1];
          pipe_we[p][s]   <= pipe_we[p][s-1];
          pipe_bank[p][s] <= pipe_bank[p][s-1];
        end
      end
    end
  end

  // Responses: data only for successful reads, taken from the bank recorded at grant time.
  always_comb begin
    port_rvalid_o = '0;
    port_err_o    = '0;
    port_rdata_o  = '0;
    for (int p = 0; p < NumPort; p++) begin
      port_rvalid_o[p] = pipe_vld[p][MemLatency-1];
      port_err_o[p]    = pipe_vld[p][MemLatency-1] & pipe_err[p][MemLatency-1];
      if (pipe_vld[p][MemLatency-1] && !pipe_err[p][MemLatency-1] && !pipe_we[p][MemLatency-1]) begin
        port_rdata_o[p] = bank_rdata_i[pipe_bank[p][MemLatency-1]];
      end
    end
  end

endmodule

// File: tb/tb_l2_bank_mapper_xbar.sv
// Bench for l2_bank_mapper_xbar: two instances (bank latency 1 and 3) driven with identical stimulus.
// Expectations come from an address-arithmetic reference model with per-bank round-robin priority.
// Bank SRAMs are modelled behaviourally per instance with their respective read latency.
module tb_l2_bank_mapper_xbar;
  import l2_map_pkg::*;

  localparam int NP  = 2;
  localparam int NB  = 4;
  localparam int AW  = 48;
  localparam int RPB = 32768;
  localparam int BAW = 15;
  localparam int MEMSZ = 1 << 20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  map_rule_t [3:0]          rules;
  logic [NP-1:0]            req, we;
  logic [NP-1:0][AW-1:0]    addr;
  logic [NP-1:0][7:0]       be;
  logic [NP-1:0][63:0]      wdata;

  logic [NP-1:0]            gnt1, rv1, err1, gnt3, rv3, err3;
  logic [NP-1:0][63:0]      rd1, rd3;
  logic [NB-1:0]            breq1, bwe1, breq3, bwe3;
  logic [NB-1:0][BAW-1:0]   baddr1, baddr3;
  logic [NB-1:0][7:0]       bbe1, bbe3;
  logic [NB-1:0][63:0]      bwd1, bwd3, brd1, brd3;

  l2_bank_mapper_xbar u_dut1 (
    .clk_i(clk), .rst_i(rst), .map_rules_i(rules),
    .port_req_i(req), .port_gnt_o(gnt1), .port_addr_i(addr), .port_we_i(we),
    .port_be_i(be), .port_wdata_i(wdata), .port_rvalid_o(rv1), .port_rdata_o(rd1),
    .port_err_o(err1), .bank_req_o(breq1), .bank_we_o(bwe1), .bank_addr_o(baddr1),
    .bank_be_o(bbe1), .bank_wdata_o(bwd1), .bank_rdata_i(brd1));

  l2_bank_mapper_xbar #(.MemLatency(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .map_rules_i(rules),
    .port_req_i(req), .port_gnt_o(gnt3), .port_addr_i(addr), .port_we_i(we),
    .port_be_i(be), .port_wdata_i(wdata), .port_rvalid_o(rv3), .port_rdata_o(rd3),
    .port_err_o(err3), .bank_req_o(breq3), .bank_we_o(bwe3), .bank_addr_o(baddr3),
    .bank_be_o(bbe3), .bank_wdata_o(bwd3), .bank_rdata_i(brd3));

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] n, input logic [7:0] b);
    logic [63:0] r;
    r = o;
    for (int k = 0; k < 8; k++) if (b[k]) r[k*8 +: 8] = n[k*8 +: 8];
    return r;
  endfunction

  // Behavioural bank SRAMs (only the first 64 rows are ever targeted by the stimulus).
  logic [63:0] mem1 [NB][64];
  logic [63:0] mem3 [NB][64];
  logic [NB-1:0][63:0] s1_3, s2_3;

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (breq1[b] && baddr1[b] < BAW'(64)) begin
        if (bwe1[b]) mem1[b][baddr1[b][5:0]] = merge(mem1[b][baddr1[b][5:0]], bwd1[b], bbe1[b]);
        else brd1[b] <= mem1[b][baddr1[b][5:0]];
      end
      if (breq3[b] && baddr3[b] < BAW'(64)) begin
        if (bwe3[b]) mem3[b][baddr3[b][5:0]] = merge(mem3[b][baddr3[b][5:0]], bwd3[b], bbe3[b]);
        else s1_3[b] <= mem3[b][baddr3[b][5:0]];
      end
      s2_3[b] <= s1_3[b];
      brd3[b] <= s2_3[b];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          err;
    logic [63:0] data;
  } exp_t;

  longint      rs [4];
  longint      re [4];
  bit          rm [4];
  logic [63:0] refm [NB][64];
  int          ptr [NB];
  exp_t        eq [2][NP][$];
  int          lat [2] = '{1, 3};
  int          cyc;
  int          n_chk, n_err;
  logic [NP-1:0] exp_gnt, obs_gnt1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void ref_decode(input longint a, output bit hit, output int bank, output int row);
    longint w;
    hit = 0; bank = 0; row = 0;
    for (int r = 0; r < 4; r++) begin
      if (a >= rs[r] && a < re[r]) begin
        if (re[r] - rs[r] <= MEMSZ) begin
          hit = 1;
          w = (a - rs[r]) / 8;
          if (!rm[r]) begin bank = int'(w % NB); row = int'(w / NB); end
          else begin bank = int'(w / RPB); row = int'(w % RPB); end
        end
        return;
      end
    end
  endfunction

  function automatic logic out_rv(input int d, input int p);  return d == 0 ? rv1[p] : rv3[p]; endfunction
  function automatic logic out_err(input int d, input int p); return d == 0 ? err1[p] : err3[p]; endfunction
  function automatic logic [63:0] out_rd(input int d, input int p); return d == 0 ? rd1[p] : rd3[p]; endfunction

  task automatic check_cycle();
    bit   hit [NP];
    int   bk [NP];
    int   rw [NP];
    int   win, p;
    exp_t e;
    logic [NP-1:0] eg;
    logic [63:0] dat;
    for (int d = 0; d < 2; d++) begin
      for (int q = 0; q < NP; q++) begin
        if (eq[d][q].size() > 0 && eq[d][q][0].due == cyc) begin
          e = eq[d][q].pop_front();
          check_val($sformatf("rvalid_d%0d_p%0d", d, q), out_rv(d, q), 1);
          check_val($sformatf("err_d%0d_p%0d", d, q), out_err(d, q), e.err);
          check_val($sformatf("rdata_d%0d_p%0d", d, q), out_rd(d, q), e.data);
        end else begin
          check_val($sformatf("rvalid_idle_d%0d_p%0d", d, q), out_rv(d, q), 0);
        end
      end
    end
    eg = '0;
    for (int q = 0; q < NP; q++) begin
      hit[q] = 0; bk[q] = 0; rw[q] = 0;
      if (req[q] && !rst) begin
        ref_decode(longint'(addr[q]), hit[q], bk[q], rw[q]);
        if (!hit[q]) eg[q] = 1'b1;
      end
    end
    for (int b = 0; b < NB; b++) begin
      win = -1;
      for (int i = 0; i < NP; i++) begin
        p = (ptr[b] + i) % NP;
        if (win < 0 && req[p] && !rst && hit[p] && bk[p] == b) win = p;
      end
      check_val($sformatf("bank_req1_b%0d", b), breq1[b], win >= 0);
      check_val($sformatf("bank_req3_b%0d", b), breq3[b], win >= 0);
      if (win >= 0) begin
        eg[win] = 1'b1;
        check_val($sformatf("bank_addr_b%0d", b), baddr1[b], rw[win]);
        check_val($sformatf("bank_we_b%0d", b), bwe1[b], we[win]);
        ptr[b] = (win + 1) % NP;
      end
    end
    obs_gnt1 = gnt1;
    check_val("gnt_lat1", gnt1, eg);
    check_val("gnt_lat3", gnt3, eg);
    for (int q = 0; q < NP; q++) begin
      if (eg[q]) begin
        dat = '0;
        if (hit[q] && rw[q] < 64) begin
          if (we[q]) refm[bk[q]][rw[q]] = merge(refm[bk[q]][rw[q]], wdata[q], be[q]);
          else dat = refm[bk[q]][rw[q]];
        end
        for (int d = 0; d < 2; d++) eq[d][q].push_back('{cyc + lat[d], !hit[q], dat});
      end
    end
    exp_gnt = eg;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drv(input int p, input bit r, input longint a, input bit w,
                     input logic [7:0] b, input logic [63:0] d);
    req[p] = r; addr[p] = AW'(a); we[p] = w; be[p] = b; wdata[p] = d;
  endtask

  function automatic longint rand_addr();
    int c;
    c = $urandom_range(0, 9);
    if (c < 5) return 64'h1000_0000 + longint'($urandom_range(0, 255)) * 8 + $urandom_range(0, 7);
    if (c < 8) return 64'h1400_0000 + longint'($urandom_range(0, 3)) * 64'h4_0000
                      + longint'($urandom_range(0, 63)) * 8;
    if (c == 8) return 64'h2000_0000 + longint'($urandom_range(0, 15)) * 8;
    return 64'h3000_0000 + longint'($urandom_range(0, 15)) * 8;
  endfunction

  task automatic rnd_req(input int p);
    if ($urandom_range(0, 9) < 7)
      drv(p, 1, rand_addr(), $urandom_range(0, 1) == 1, 8'($urandom), {$urandom, $urandom});
    else
      req[p] = 1'b0;
  endtask

  int w0, w1;

  initial begin
    n_chk = 0; n_err = 0; cyc = 0;
    // rule0 interleaved, rule1 contiguous, rule2 oversized, rule3 overlaps rule0 and must lose
    rs[0] = 64'h1000_0000; re[0] = 64'h1010_0000; rm[0] = 0;
    rs[1] = 64'h1400_0000; re[1] = 64'h1410_0000; rm[1] = 1;
    rs[2] = 64'h3000_0000; re[2] = 64'h3020_0000; rm[2] = 0;
    rs[3] = 64'h1000_0000; re[3] = 64'h1010_0000; rm[3] = 1;
    for (int r = 0; r < 4; r++) begin
      rules[r].mode       = rm[r] ? CONTIGUOUS : INTERLEAVE;
      rules[r].start_addr = 48'(rs[r]);
      rules[r].end_addr   = 48'(re[r]);
    end
    for (int b = 0; b < NB; b++) begin
      ptr[b] = 0;
      for (int r = 0; r < 64; r++) begin mem1[b][r] = '0; mem3[b][r] = '0; refm[b][r] = '0; end
    end
    req = '0; we = '0; addr = '0; be = '0; wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_rvalid1", rv1, 0);
    check_val("rst_rvalid3", rv3, 0);
    check_val("rst_err1", err1, 0);
    check_val("rst_rdata1", rd1[0] | rd1[1], 0);
    check_val("rst_bank_req1", breq1, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Five interleaved writes from P0: banks 0,1,2,3,0 rows 0,0,0,0,1
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, 64'h1000_0000 + i * 8, 1, 8'hFF, 64'hA5A5_0000_0000_0000 | i);
      step();
    end
    req = '0; repeat (3) step();
    // Back-to-back reads of the same words (exercises the 3-cycle instance at full rate)
    for (int i = 0; i < 5; i++) begin
      drv(0, 1, 64'h1000_0000 + i * 8, 0, 8'h00, 64'h0);
      step();
    end
    req = '0; repeat (4) step();

    // Contiguous window: 0x1404_0000 -> bank 1 row 0, full then partial write, each read back
    drv(1, 1, 64'h1404_0000, 1, 8'hFF, 64'hDEAD_BEEF_CAFE_0001); step();
    drv(1, 1, 64'h1404_0000, 0, 8'h00, 64'h0); step();
    drv(1, 1, 64'h1404_0000, 1, 8'h0F, 64'h1111_2222_3333_4444); step();
    drv(1, 1, 64'h1404_0000, 0, 8'h00, 64'h0); step();
    req = '0; repeat (4) step();

    // Both ports on bank 2 for four cycles: grants must split evenly
    w0 = 0; w1 = 0;
    drv(0, 1, 64'h1000_0010, 0, 8'h00, 64'h0);
    drv(1, 1, 64'h1000_0030, 0, 8'h00, 64'h0);
    repeat (4) begin
      step();
      w0 += int'(obs_gnt1[0]);
      w1 += int'(obs_gnt1[1]);
    end
    check_val("conflict_p0_wins", w0, 2);
    check_val("conflict_p1_wins", w1, 2);
    req = '0; repeat (4) step();

    // Unmapped address and oversized window: both decode errors without bank access
    drv(1, 1, 64'h2000_0000, 0, 8'h00, 64'h0); step();
    drv(0, 1, 64'h3000_0008, 1, 8'hFF, 64'h55); step();
    req = '0; repeat (4) step();

    // Reset with reads outstanding; P0 leaves bank 2 pointing at P1 beforehand
    drv(0, 1, 64'h1000_0010, 0, 8'h00, 64'h0); step();
    drv(0, 1, 64'h1000_0030, 0, 8'h00, 64'h0); step();
    req = '0;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) for (int q = 0; q < NP; q++) eq[d][q].delete();
    for (int b = 0; b < NB; b++) ptr[b] = 0;
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    drv(0, 1, 64'h1000_0010, 0, 8'h00, 64'h0);
    drv(1, 1, 64'h1000_0030, 0, 8'h00, 64'h0);
    step();
    check_val("post_rst_first_gnt", obs_gnt1, 2'b01);
    step();
    req = '0; repeat (4) step();

    // Randomised traffic; a request is held until the model says it was granted
    for (int p = 0; p < NP; p++) rnd_req(p);
    repeat (400) begin
      step();
      for (int p = 0; p < NP; p++) if (!req[p] || exp_gnt[p]) rnd_req(p);
    end
    req = '0; repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
